hamming_secded_rx: RTL and testbench
====================================

# hamming_secded_rx

Serial receiver for Hamming(8,4) SEC-DED codewords: 7-bit Hamming(7,4) plus one overall parity bit. It deserializes 8-bit codewords, computes the syndrome and overall parity, and corrects single-bit errors. It flags uncorrectable double-bit errors and re-serializes the 4 data bits. It is the receive end of the SEC-DED serial link and pairs with the SEC-DED serial encoder on the same `enable` bit pacing.

## Interface
Parameters
- CNT_W, 8, width of the saturating error counters

Ports
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- enable  input  1  input bit-valid; `datain` is sampled only on edges where `enable`=1
- datain  input  1  serial codeword bit
- dataout  output  1  serial corrected data bit
- clkd  output  1  high while `dataout` carries a valid data bit
- clkc  output  1  one-cycle pulse: codeword decoded
- syndrome  output  3  {s4,s2,s1} of last codeword
- err_single  output  1  last codeword had a corrected error (incl. p0-only)
- err_double  output  1  last codeword had an uncorrectable double error
- corr_count  output  CNT_W  saturating count of corrected codewords
- dbl_count  output  CNT_W  saturating count of double-error codewords

## Operation
- Codeword bit order on the wire, first to last: pos1 p1, pos2 p2, pos3 d1, pos4 p4, pos5 d2, pos6 d3, pos7 d4, pos8 p0. p0 is the XOR of pos1..7.
- Input capture: a 3-bit counter `bitcnt` is 0..7 and advances only when `enable`=1. A shift register captures `datain` on the same edges. `bitcnt` wraps 7→0. Codeword alignment is fixed by reset: the first enabled bit after reset is pos1.
- Decode is combinational on the completed 8 bits and is registered on the edge that samples pos8.
  - s1 = pos1^3^5^7, s2 = pos2^3^6^7, s4 = pos4^5^6^7, P = XOR of pos1..8.
  - s=0, P=0: clean. Data is passed through; both flags are 0.
  - s≠0, P=1: single error. The bit at position s is inverted; err_single=1.
  - s=0, P=1: p0 error. Data is passed through; err_single=1.
  - s≠0, P=0: double error. Data is passed through uncorrected; err_double=1.
- Flags and `syndrome` are updated at each decode and hold until the next decode.
- Counters increment by 1 on each flagged decode and saturate at 2^CNT_W−1 (no wrap).
- Output serializer:
  - The corrected nibble is loaded at decode. The shifter then emits d1, d2, d3, d4 on 4 consecutive cycles with `clkd`=1.
  - The serializer runs independently of `enable`.
  - The minimum 8 cycles between decodes guarantees the serializer is idle before the next load. No overlap condition exists.
- Outputs are registered; `dataout`=0 whenever `clkd`=0.

## Timing
- Reset (async assert, sync release to clk): bitcnt=0; all outputs 0 (dataout, clkd, clkc, syndrome=3'b000, err_single, err_double, corr_count, dbl_count). Any partial codeword is discarded.
- Pos8 sampled at edge E. In the cycle after E: clkc=1 (exactly one cycle), flags/syndrome/counters updated, clkd=1, dataout=d1.
- d2, d3, d4 follow on the next 3 cycles. clkd drops after d4.
- Latency: last codeword bit to first data bit is 1 cycle; to last data bit is 4 cycles.
- enable=0 mid-codeword: bitcnt and the capture shift register hold. Draining of the previous nibble continues.
- Back-to-back codewords (enable held high): clkc every 8 cycles; clkd high 4 of every 8 cycles.
- Reset asserted mid-serialization: clkd and dataout drop immediately. The remaining bits are lost.

## Test plan
- Clean codeword: data 1011, send 0,1,1,0,0,1,1,0 with enable=1 → clkc pulse; dataout 1,0,1,1 with clkd; syndrome=000; flags 0; counters 0.
- Single error: flip pos5, send 0,1,1,0,1,1,1,0 → syndrome=101, err_single=1, dataout 1,0,1,1, corr_count=1.
- Double error: flip pos3 and pos5, send 0,1,0,0,1,1,1,0 → syndrome=110, err_double=1, dataout = uncorrected 0,1,1,1, dbl_count=1.
- p0-only error: send 0,1,1,0,0,1,1,1 → syndrome=000, err_single=1, dataout 1,0,1,1.
- Gaps and reset: insert enable=0 for 5 cycles after pos3 → same output as the clean case, delayed 5 cycles. Assert reset after pos4 of the next codeword, then send a clean codeword → correctly aligned decode.
- Saturation: CNT_W=2, send 5 single-error codewords → corr_count sticks at 3; back-to-back stream yields clkc every 8 cycles.

Source files
------------

// File: rtl/hamming_secded_rx.sv
// hamming_secded_rx: serial Hamming(8,4) SEC-DED receiver.
// Deserializes codewords, corrects single errors, flags double errors, re-serializes d1..d4.
`default_nettype none

module hamming_secded_rx #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             datain,
   output logic             dataout,
   output logic             clkd,
   output logic             clkc,
   output logic [2:0]       syndrome,
   output logic             err_single,
   output logic             err_double,
   output logic [CNT_W-1:0] corr_count,
   output logic [CNT_W-1:0] dbl_count
);

   logic [2:0] bitcnt;
   logic [6:0] cw;          // cw[k] holds position k+1 once pos1..7 are in
   logic [2:0] ser_sh;
   logic [1:0] ser_left;

   logic [7:0] word;
   logic       decode_now;
   logic       s1, s2, s4, par;
   logic [2:0] syn;
   logic [6:0] flip;
   logic [6:0] fixed;
   logic [3:0] nib;
   logic       is_single, is_double;

   // Pos8 is taken straight from datain so the decode lands on the edge that samples it.
   assign word       = {datain, cw};
   assign decode_now = enable && (bitcnt == 3'd7);

   always_comb begin
      s1        = word[0] ^ word[2] ^ word[4] ^ word[6];
      s2        = word[1] ^ word[2] ^ word[5] ^ word[6];
      s4        = word[3] ^ word[4] ^ word[5] ^ word[6];
      par       = ^word;
      syn       = {s4, s2, s1};
      is_single = par;
      is_double = (syn != 3'd0) && !par;
      flip      = 7'd0;
      if (par && (syn != 3'd0))
         flip = 7'b000_0001 << (syn - 3'd1);
      fixed     = word[6:0] ^ flip;
      nib       = {fixed[6], fixed[5], fixed[4], fixed[2]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bitcnt <= 3'd0;
         cw     <= 7'd0;
      end else if (enable) begin
         bitcnt <= bitcnt + 3'd1;
         cw     <= {datain, cw[6:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clkc       <= 1'b0;
         syndrome   <= 3'd0;
         err_single <= 1'b0;
         err_double <= 1'b0;
         corr_count <= '0;
         dbl_count  <= '0;
      end else begin
         clkc <= decode_now;
         if (decode_now) begin
            syndrome   <= syn;
            err_single <= is_single;
            err_double <= is_double;
            if (is_single && (corr_count != {CNT_W{1'b1}}))
               corr_count <= corr_count + CNT_W'(1);
            if (is_double && (dbl_count != {CNT_W{1'b1}}))
               dbl_count <= dbl_count + CNT_W'(1);
         end
      end
   end

   // d1 goes out at load; ser_left counts the bits still queued behind it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout  <= 1'b0;
         clkd     <= 1'b0;
         ser_sh   <= 3'd0;
         ser_left <= 2'd0;
      end else if (decode_now) begin
         dataout  <= nib[0];
         clkd     <= 1'b1;
         ser_sh   <= nib[3:1];
         ser_left <= 2'd3;
      end else if (ser_left != 2'd0) begin
         dataout  <= ser_sh[0];
         ser_sh   <= {1'b0, ser_sh[2:1]};
         ser_left <= ser_left - 2'd1;
      end else begin
         dataout <= 1'b0;
         clkd    <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hamming_secded_rx.sv
// tb_hamming_secded_rx: directed self-checking bench for hamming_secded_rx (CNT_W=2).
`default_nettype none

module tb_hamming_secded_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       datain;
   logic       dataout, clkd, clkc, err_single, err_double;
   logic [2:0] syndrome;
   logic [1:0] corr_count, dbl_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Observations taken after a codeword completes
   logic       o_clkc, o_clkc2, o_es, o_ed, o_tail_kd, o_tail_d;
   logic [2:0] o_syn;
   logic [1:0] o_cc, o_dc;
   logic [3:0] o_d, o_kd;

   hamming_secded_rx #(.CNT_W(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .datain(datain),
      .dataout(dataout), .clkd(clkd), .clkc(clkc), .syndrome(syndrome),
      .err_single(err_single), .err_double(err_double),
      .corr_count(corr_count), .dbl_count(dbl_count)
   );

   always #5 clk = ~clk;

   // Bits driven on negedges, pos1 first; an idle gap can be inserted before bit gap_at.
   task automatic send_cw(input logic [0:7] v, input int gap_at, input int gap_len);
      for (int i = 0; i < 8; i++) begin
         if (i == gap_at)
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk); enable = 1'b0; datain = 1'b0;
            end
         @(negedge clk); enable = 1'b1; datain = v[i];
      end
   endtask

   task automatic capture();
      @(negedge clk); enable = 1'b0; datain = 1'b0;
      o_clkc = clkc; o_syn = syndrome; o_es = err_single; o_ed = err_double;
      o_cc = corr_count; o_dc = dbl_count; o_d[0] = dataout; o_kd[0] = clkd;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         o_d[k] = dataout; o_kd[k] = clkd;
         if (k == 1) o_clkc2 = clkc;
      end
      @(negedge clk);
      o_tail_kd = clkd; o_tail_d = dataout;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; datain = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({dataout, clkd, clkc, syndrome, err_single, err_double, corr_count, dbl_count} !== 12'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %b want all zero",
            {dataout, clkd, clkc, syndrome, err_single, err_double, corr_count, dbl_count}); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ({dataout, clkd, clkc, syndrome, err_single, err_double, corr_count, dbl_count} !== 12'd0) begin
         n_bad++; $display("FAIL reset_idle: got %b want all zero",
            {dataout, clkd, clkc, syndrome, err_single, err_double, corr_count, dbl_count}); end
   endtask

   task automatic test_clean(input int gap_at, input int gap_len);
      send_cw(8'b01100110, gap_at, gap_len);
      capture();
      n_cmp++; if (o_clkc !== 1'b1 || o_clkc2 !== 1'b0) begin n_bad++;
         $display("FAIL clean_clkc: got %b%b want 10", o_clkc, o_clkc2); end
      n_cmp++; if (o_kd !== 4'b1111 || o_tail_kd !== 1'b0) begin n_bad++;
         $display("FAIL clean_clkd: got %b/%b want 1111/0", o_kd, o_tail_kd); end
      n_cmp++; if (o_d !== 4'b1101 || o_tail_d !== 1'b0) begin n_bad++;
         $display("FAIL clean_data: got %b/%b want 1101/0", o_d, o_tail_d); end
      n_cmp++; if ({o_syn, o_es, o_ed} !== 5'b000_00) begin n_bad++;
         $display("FAIL clean_flags: got %b want 00000", {o_syn, o_es, o_ed}); end
   endtask

   task automatic test_single();
      send_cw(8'b01101110, 8, 0);
      capture();
      n_cmp++; if (o_syn !== 3'b101) begin n_bad++;
         $display("FAIL single_syndrome: got %b want 101", o_syn); end
      n_cmp++; if (o_es !== 1'b1 || o_ed !== 1'b0) begin n_bad++;
         $display("FAIL single_flags: got %b%b want 10", o_es, o_ed); end
      n_cmp++; if (o_d !== 4'b1101 || o_kd !== 4'b1111) begin n_bad++;
         $display("FAIL single_data: got %b/%b want 1101/1111", o_d, o_kd); end
      n_cmp++; if (o_cc !== 2'd1 || o_dc !== 2'd0) begin n_bad++;
         $display("FAIL single_counts: got %0d/%0d want 1/0", o_cc, o_dc); end
   endtask

   task automatic test_double();
      send_cw(8'b01001110, 8, 0);
      capture();
      n_cmp++; if (o_syn !== 3'b110) begin n_bad++;
         $display("FAIL double_syndrome: got %b want 110", o_syn); end
      n_cmp++; if (o_es !== 1'b0 || o_ed !== 1'b1) begin n_bad++;
         $display("FAIL double_flags: got %b%b want 01", o_es, o_ed); end
      n_cmp++; if (o_d !== 4'b1110) begin n_bad++;
         $display("FAIL double_data: got %b want 1110", o_d); end
      n_cmp++; if (o_cc !== 2'd1 || o_dc !== 2'd1) begin n_bad++;
         $display("FAIL double_counts: got %0d/%0d want 1/1", o_cc, o_dc); end
   endtask

   task automatic test_p0();
      send_cw(8'b01100111, 8, 0);
      capture();
      n_cmp++; if ({o_syn, o_es, o_ed} !== 5'b000_10) begin n_bad++;
         $display("FAIL p0_flags: got %b want 00010", {o_syn, o_es, o_ed}); end
      n_cmp++; if (o_d !== 4'b1101) begin n_bad++;
         $display("FAIL p0_data: got %b want 1101", o_d); end
      n_cmp++; if (o_cc !== 2'd2 || o_dc !== 2'd1) begin n_bad++;
         $display("FAIL p0_counts: got %0d/%0d want 2/1", o_cc, o_dc); end
   endtask

   task automatic test_reset_mid();
      logic [0:7] v;
      v = 8'b01101110;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); enable = 1'b1; datain = v[i];
      end
      @(negedge clk); enable = 1'b0; datain = 1'b0; reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      send_cw(8'b01100110, 8, 0);
      capture();
      n_cmp++; if (o_clkc !== 1'b1 || o_d !== 4'b1101 || o_kd !== 4'b1111) begin n_bad++;
         $display("FAIL realign_decode: got clkc=%b d=%b kd=%b want 1/1101/1111", o_clkc, o_d, o_kd); end
      n_cmp++; if ({o_syn, o_es, o_ed, o_cc, o_dc} !== 9'd0) begin n_bad++;
         $display("FAIL realign_status: got %b want 0", {o_syn, o_es, o_ed, o_cc, o_dc}); end
   endtask

   task automatic test_reset_serial();
      send_cw(8'b01101110, 8, 0);
      @(negedge clk); enable = 1'b0; datain = 1'b0;
      n_cmp++; if (clkd !== 1'b1 || corr_count !== 2'd1) begin n_bad++;
         $display("FAIL preabort_state: got clkd=%b cc=%0d want 1/1", clkd, corr_count); end
      @(negedge clk); reset = 1'b0;
      #1;
      n_cmp++; if ({clkd, dataout, clkc, corr_count} !== 5'd0) begin n_bad++;
         $display("FAIL abort_outputs: got %b want 00000", {clkd, dataout, clkc, corr_count}); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (clkd !== 1'b0) begin n_bad++;
         $display("FAIL abort_stays_idle: got clkd=%b want 0", clkd); end
   endtask

   // Five single-error codewords with enable held high: checks pacing and saturation at 3.
   task automatic test_back_to_back();
      logic [0:7] v;
      logic [0:3] pat;
      logic       e_clkc, e_clkd, e_d;
      logic [1:0] e_cc;
      int         m;
      v   = 8'b01101110;
      pat = 4'b1011;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         m      = n % 8;
         e_clkc = (n >= 8) && (m == 0);
         e_clkd = (n >= 8) && (m < 4);
         e_d    = e_clkd ? pat[m] : 1'b0;
         n_cmp++; if (clkc !== e_clkc || clkd !== e_clkd || dataout !== e_d) begin n_bad++;
            $display("FAIL b2b_cycle%0d: got clkc=%b clkd=%b d=%b want %b %b %b",
                     n, clkc, clkd, dataout, e_clkc, e_clkd, e_d); end
         if (n >= 8 && m == 0) begin
            e_cc = (n / 8 >= 3) ? 2'd3 : 2'(n / 8);
            n_cmp++; if (corr_count !== e_cc || dbl_count !== 2'd0) begin n_bad++;
               $display("FAIL b2b_count%0d: got %0d/%0d want %0d/0", n / 8, corr_count, dbl_count, e_cc); end
         end
         if (n < 40) begin enable = 1'b1; datain = v[m]; end
         else begin enable = 1'b0; datain = 1'b0; end
      end
   endtask

   initial begin
      test_reset();
      test_clean(8, 0);
      test_single();
      test_double();
      test_p0();
      test_clean(3, 5);
      test_reset_mid();
      test_reset_serial();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
